// File: rtl/firing_pkg.sv
// Shared encodings between the firing control FSM and the firing datapath.
package firing_pkg;

    // Commands driven onto the datapath control bus
    localparam logic [2:0] CTRL_RELOAD = 3'b000;
    localparam logic [2:0] CTRL_HOLD   = 3'b001;
    localparam logic [2:0] CTRL_SHOT   = 3'b011;

    typedef logic [3:0] state_t;

    // Control FSM state encoding
    localparam state_t ST_WAIT     = 4'd0;
    localparam state_t ST_ARMED    = 4'd1;
    localparam state_t ST_FIRE     = 4'd2;
    localparam state_t ST_FLASH    = 4'd3;
    localparam state_t ST_CHECK    = 4'd4;
    localparam state_t ST_EVAL     = 4'd5;
    localparam state_t ST_END_HIT  = 4'd6;
    localparam state_t ST_END_MISS = 4'd7;
    localparam state_t ST_COOLDOWN = 4'd8;

    // Datapath command issued while sitting in a given state
    function automatic logic [2:0] control_of(input state_t st);
        logic [2:0] ctrl;
        case (st)
            ST_FIRE:  ctrl = CTRL_SHOT;
            ST_CHECK: ctrl = CTRL_RELOAD;
            default:  ctrl = CTRL_HOLD;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/trigger_debouncer.sv
// Gun button conditioning: 2-flop synchronizer, debounce counter and
// registered rising-edge pulse of the debounced level.
module trigger_debouncer #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic        sync_q1;
    logic        sync_q2;
    logic        level_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Counter reloads while the synchronized input agrees with the level, so a
    // flip needs DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_comb begin
        level_d = level;
        cnt_d   = cnt_q;
        if (sync_q2 == level) begin
            cnt_d = DEBOUNCE_CYCLES - 16'd1;
        end else if (cnt_q == 16'd0) begin
            level_d = sync_q2;
            cnt_d   = DEBOUNCE_CYCLES - 16'd1;
        end else begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    // Synchronizer, debounce state and edge pulse registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt_q   <= 16'd0;
            level   <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            cnt_q   <= cnt_d;
            level   <= level_d;
            rise    <= level_d & ~level;
        end
    end

endmodule

// File: rtl/firing_control.sv
// Shot sequencing FSM: arms on a new round, fires on a debounced trigger
// press, shows the flash, reloads, evaluates the result and paces retries.
module firing_control
    import firing_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [15:0] FLASH_CYCLES    = 16'd3000,
    parameter logic [15:0] COOLDOWN_CYCLES = 16'd6000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       trigger,
    input  logic       round_start,
    input  logic       is_shot,
    input  logic       escape,
    input  logic [1:0] remaining_shots,
    output logic [2:0] control,
    output logic       leave,
    output logic       shot_flash,
    output logic       hit,
    output logic       missed,
    output logic       busy
);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        trig_level;
    logic        trig_rise;
    logic        fire_req;

    trigger_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_trigger_debouncer (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (trigger),
        .level  (trig_level),
        .rise   (trig_rise)
    );

    // A rise is always accompanied by a high level; gating on both keeps any
    // stale pulse from firing after a release.
    assign fire_req = trig_rise & trig_level;

    // Next-state and dwell-counter logic; counters load on entry and stop at 0
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (round_start) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                // Out of ammo: skip straight to reload/evaluate
                if (remaining_shots == 2'd0) state_d = ST_CHECK;
                else if (fire_req)           state_d = ST_FIRE;
            end
            ST_FIRE: begin
                state_d = ST_FLASH;
                cnt_d   = FLASH_CYCLES - 16'd1;
            end
            ST_FLASH: begin
                if (cnt_q == 16'd0) state_d = ST_CHECK;
                else                cnt_d   = cnt_q - 16'd1;
            end
            ST_CHECK: begin
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
                if (is_shot) begin
                    state_d = ST_END_HIT;
                end else if (escape) begin
                    state_d = ST_END_MISS;
                end else begin
                    state_d = ST_COOLDOWN;
                    cnt_d   = COOLDOWN_CYCLES - 16'd1;
                end
            end
            ST_END_HIT, ST_END_MISS: begin
                state_d = ST_WAIT;
            end
            ST_COOLDOWN: begin
                if (cnt_q == 16'd0) state_d = ST_ARMED;
                else                cnt_d   = cnt_q - 16'd1;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    // State, counter and outputs; outputs are decoded from the next state so
    // they line up with the registered state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_WAIT;
            cnt_q      <= 16'd0;
            control    <= CTRL_HOLD;
            leave      <= 1'b0;
            shot_flash <= 1'b0;
            hit        <= 1'b0;
            missed     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            control    <= control_of(state_d);
            leave      <= (state_d == ST_END_HIT) || (state_d == ST_END_MISS);
            shot_flash <= (state_d == ST_FLASH);
            hit        <= (state_d == ST_END_HIT);
            missed     <= (state_d == ST_END_MISS);
            busy       <= (state_d != ST_WAIT);
        end
    end

endmodule

// File: tb/tb_firing_control.sv
// Bench for firing_control with a behavioural firing datapath and an event
// scoreboard fed by the stimulus tasks and drained by an output monitor.
module tb_firing_control;
    import firing_pkg::*;

    localparam int EV_SHOT  = 1;
    localparam int EV_FLASH = 2;
    localparam int EV_COOL  = 3;
    localparam int EV_HIT   = 4;
    localparam int EV_MISS  = 5;
    localparam int EV_LEAVE = 6;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic       clk;
    logic       reset_n;
    logic       trigger;
    logic       round_start;
    logic       is_shot;
    logic       escape;
    logic [1:0] remaining_shots;
    logic [2:0] control;
    logic       leave;
    logic       shot_flash;
    logic       hit;
    logic       missed;
    logic       busy;

    logic       bird_over;
    logic       force_empty;
    logic [1:0] dp_rem;

    int   vectors;
    int   miscompares;
    ev_t  exp_q[$];
    ev_t  obs_q[$];
    int   shot_run;
    int   flash_run;
    int   cool_run;

    firing_control #(
        .DEBOUNCE_CYCLES(16'd4),
        .FLASH_CYCLES   (16'd8),
        .COOLDOWN_CYCLES(16'd16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .trigger        (trigger),
        .round_start    (round_start),
        .is_shot        (is_shot),
        .escape         (escape),
        .remaining_shots(remaining_shots),
        .control        (control),
        .leave          (leave),
        .shot_flash     (shot_flash),
        .hit            (hit),
        .missed         (missed),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign remaining_shots = force_empty ? 2'd0 : dp_rem;

    // Firing datapath model: a shot uses a round, hits if the bird overlaps,
    // and the last miss lets the bird escape; leave restores a fresh round.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dp_rem  <= 2'd3;
            is_shot <= 1'b0;
            escape  <= 1'b0;
        end else if (leave) begin
            dp_rem  <= 2'd3;
            is_shot <= 1'b0;
            escape  <= 1'b0;
        end else if (control == CTRL_SHOT && dp_rem != 2'd0) begin
            dp_rem <= dp_rem - 2'd1;
            if (bird_over)           is_shot <= 1'b1;
            else if (dp_rem == 2'd1) escape  <= 1'b1;
        end
    end

    // Monitor: turns output activity into events and checks them in order
    always @(negedge clk) begin
        obs_q.delete();
        if (!reset_n) begin
            shot_run  = 0;
            flash_run = 0;
            cool_run  = 0;
        end else begin
            if (control == CTRL_SHOT) shot_run++;
            else if (shot_run > 0) begin
                obs_q.push_back('{kind: EV_SHOT, val: shot_run});
                shot_run = 0;
            end
            if (shot_flash) flash_run++;
            else if (flash_run > 0) begin
                obs_q.push_back('{kind: EV_FLASH, val: flash_run});
                flash_run = 0;
            end
            if (dut.state_q == ST_COOLDOWN) cool_run++;
            else if (cool_run > 0) begin
                obs_q.push_back('{kind: EV_COOL, val: cool_run});
                cool_run = 0;
            end
            if (hit)    obs_q.push_back('{kind: EV_HIT, val: 0});
            if (missed) obs_q.push_back('{kind: EV_MISS, val: 0});
            if (leave)  obs_q.push_back('{kind: EV_LEAVE, val: 0});
            foreach (obs_q[i]) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    $display("FAIL event @%0t: got kind=%0d val=%0d, expected none",
                             $time, obs_q[i].kind, obs_q[i].val);
                    miscompares++;
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (obs_q[i].kind !== e.kind || obs_q[i].val !== e.val) begin
                        $display("FAIL event @%0t: got kind=%0d val=%0d, expected kind=%0d val=%0d",
                                 $time, obs_q[i].kind, obs_q[i].val, e.kind, e.val);
                        miscompares++;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_round_start();
        round_start = 1'b1;
        tick(1);
        round_start = 1'b0;
    endtask

    task automatic press(input int hi, input int lo);
        trigger = 1'b1;
        tick(hi);
        trigger = 1'b0;
        tick(lo);
    endtask

    task automatic expect_ev(input int kind, input int val);
        exp_q.push_back('{kind: kind, val: val});
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        vectors++;
        if (busy !== 1'b0) begin
            $display("FAIL %s: busy=%b, required 0 within 200 cycles", name, busy);
            miscompares++;
        end
        tick(2);
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            $display("FAIL %s: %0d expected events outstanding, required 0", name, exp_q.size());
            miscompares++;
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        vectors += 6;
        if (control !== 3'b001) begin
            $display("FAIL reset_control: got %b, required 001", control); miscompares++;
        end
        if (leave !== 1'b0) begin
            $display("FAIL reset_leave: got %b, required 0", leave); miscompares++;
        end
        if (shot_flash !== 1'b0) begin
            $display("FAIL reset_flash: got %b, required 0", shot_flash); miscompares++;
        end
        if (hit !== 1'b0) begin
            $display("FAIL reset_hit: got %b, required 0", hit); miscompares++;
        end
        if (missed !== 1'b0) begin
            $display("FAIL reset_missed: got %b, required 0", missed); miscompares++;
        end
        if (busy !== 1'b0) begin
            $display("FAIL reset_busy: got %b, required 0", busy); miscompares++;
        end
        reset_n = 1'b1;
        tick(3);
    endtask

    task automatic test_hit();
        bird_over = 1'b1;
        expect_ev(EV_SHOT, 1);
        expect_ev(EV_FLASH, 8);
        expect_ev(EV_HIT, 0);
        expect_ev(EV_LEAVE, 0);
        pulse_round_start();
        press(10, 10);
        wait_idle("hit_idle");
        check_drained("hit_events");
        vectors++;
        if (dp_rem !== 2'd3) begin
            $display("FAIL hit_remaining: got %0d, required 3", dp_rem); miscompares++;
        end
    endtask

    task automatic test_three_misses();
        bird_over = 1'b0;
        for (int s = 0; s < 3; s++) begin
            expect_ev(EV_SHOT, 1);
            expect_ev(EV_FLASH, 8);
            if (s < 2) expect_ev(EV_COOL, 16);
        end
        expect_ev(EV_MISS, 0);
        expect_ev(EV_LEAVE, 0);
        pulse_round_start();
        for (int s = 0; s < 3; s++) begin
            press(10, 10);
            tick(40);
        end
        wait_idle("miss_idle");
        check_drained("miss_events");
    endtask

    task automatic test_bounce();
        bird_over = 1'b1;
        expect_ev(EV_SHOT, 1);
        expect_ev(EV_FLASH, 8);
        expect_ev(EV_HIT, 0);
        expect_ev(EV_LEAVE, 0);
        pulse_round_start();
        for (int c = 0; c < 20; c++) begin
            trigger = ((c / 2) % 2 == 0);
            tick(1);
        end
        press(10, 10);
        wait_idle("bounce_idle");
        check_drained("bounce_events");
    endtask

    task automatic test_held_through_cooldown();
        bird_over = 1'b0;
        expect_ev(EV_SHOT, 1);
        expect_ev(EV_FLASH, 8);
        expect_ev(EV_COOL, 16);
        pulse_round_start();
        trigger = 1'b1;
        tick(60);
        check_drained("held_no_refire");
        trigger = 1'b0;
        tick(10);
        expect_ev(EV_SHOT, 1);
        expect_ev(EV_FLASH, 8);
        expect_ev(EV_COOL, 16);
        press(10, 10);
        tick(30);
        check_drained("held_repress");
    endtask

    // Entered from ARMED with one round left, so this shot would end in a miss
    task automatic test_reset_in_flash();
        bool_wait_flash("rst_flash");
        vectors += 6;
        if (control !== 3'b001) begin
            $display("FAIL rstmid_control: got %b, required 001", control); miscompares++;
        end
        if (leave !== 1'b0) begin
            $display("FAIL rstmid_leave: got %b, required 0", leave); miscompares++;
        end
        if (shot_flash !== 1'b0) begin
            $display("FAIL rstmid_flash: got %b, required 0", shot_flash); miscompares++;
        end
        if (hit !== 1'b0) begin
            $display("FAIL rstmid_hit: got %b, required 0", hit); miscompares++;
        end
        if (missed !== 1'b0) begin
            $display("FAIL rstmid_missed: got %b, required 0", missed); miscompares++;
        end
        if (busy !== 1'b0) begin
            $display("FAIL rstmid_busy: got %b, required 0", busy); miscompares++;
        end
        tick(3);
        reset_n = 1'b1;
        tick(30);
        check_drained("rstmid_events");
        vectors++;
        if (busy !== 1'b0) begin
            $display("FAIL rstmid_idle: busy=%b, required 0", busy); miscompares++;
        end
    endtask

    task automatic bool_wait_flash(input string name);
        bird_over = 1'b0;
        expect_ev(EV_SHOT, 1);
        trigger = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (shot_flash) break;
        end
        vectors++;
        if (shot_flash !== 1'b1) begin
            $display("FAIL %s: shot_flash=%b, required 1 within 50 cycles", name, shot_flash);
            miscompares++;
        end
        tick(3);
        trigger = 1'b0;
        reset_n = 1'b0;
        #1;
    endtask

    task automatic test_round_start_ignored();
        bird_over = 1'b1;
        expect_ev(EV_SHOT, 1);
        expect_ev(EV_FLASH, 8);
        expect_ev(EV_HIT, 0);
        expect_ev(EV_LEAVE, 0);
        pulse_round_start();
        trigger = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (shot_flash) break;
        end
        tick(2);
        pulse_round_start();
        trigger = 1'b0;
        wait_idle("rs_idle");
        tick(5);
        vectors++;
        if (busy !== 1'b0) begin
            $display("FAIL rs_stays_idle: busy=%b, required 0", busy); miscompares++;
        end
        check_drained("rs_events");
    endtask

    task automatic test_empty_recovery();
        bird_over = 1'b0;
        force_empty = 1'b1;
        expect_ev(EV_COOL, 16);
        pulse_round_start();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (control == CTRL_RELOAD) break;
        end
        vectors++;
        if (control !== CTRL_RELOAD) begin
            $display("FAIL empty_reload: control=%b, required 000 within 10 cycles", control);
            miscompares++;
        end
        tick(24);
        check_drained("empty_events");
        reset_n = 1'b0;
        force_empty = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        shot_run    = 0;
        flash_run   = 0;
        cool_run    = 0;
        trigger     = 1'b0;
        round_start = 1'b0;
        bird_over   = 1'b0;
        force_empty = 1'b0;
        reset_n     = 1'b0;
        test_reset();
        test_hit();
        test_three_misses();
        test_bounce();
        test_held_through_cooldown();
        test_reset_in_flash();
        test_round_start_ignored();
        test_empty_recovery();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
